uart_rx_bit_sampler: RTL
========================

// Module: uart_rx_bit_sampler
// PURPOSE
//  Front end of the UART Rx path, directly upstream of the byte analyser.
//  - Synchronises the serial line and oversamples it 16x on BaudSig_i.
//  - Majority-votes each bit and assembles a 12-bit frame word.
//  - Raises Byte_Synch_o for each frame with a valid stop bit, for the analyser to latch.
// PARAMETERS
//  SYNC_STAGES  3  flops in the Rx_i synchroniser (>=2)
//  SAMPLE_MID   8  centre tick of bit; vote uses ticks SAMPLE_MID-1..SAMPLE_MID+1 (range 2..13)
// PORTS
//  clk                input   1   system clock (>=40 MHz)
//  rst                input   1   asynchronous, active-high reset
//  Rx_i               input   1   raw serial line, idle high
//  BaudSig_i          input   1   1-clk pulse, 16 per bit time
//  p_ParityEnable_i   input   1   1 = frame carries a parity bit
//  byte_o             output  12  frame word, see BEHAVIOUR
//  Bit_Synch_o        output  1   1-clk pulse per voted bit
//  Byte_Synch_o       output  1   1-clk pulse: byte_o valid and stable
//  State_o            output  5   one-hot FSM state
//  BitWidthCnt_o      output  4   tick counter within current bit
//  p_FrameError_o     output  1   1-clk pulse: stop bit voted 0
// BEHAVIOUR
//  Reset values: byte_o=12'h000, State_o=IDLE, BitWidthCnt_o=0, all pulses 0; synchroniser flops=1.
//  Assertion of rst mid-frame aborts the frame; no Byte_Synch_o follows release.
//  States: IDLE=5'b0_0001, STRT=5'b0_0010, DATA=5'b0_0100, PARI=5'b0_1000, STOP=5'b1_0000.
//  Bit timing:
//   - BitWidthCnt increments on each BaudSig_i outside IDLE and wraps 15->0.
//   - The wrap marks the bit boundary.
//   - 3 vote samples are taken at ticks MID-1, MID, MID+1; vote = majority.
//   - Bit_Synch_o pulses 1 clk after the MID+1 tick.
//  State transitions:
//   - IDLE->STRT: falling edge on synchronised Rx; BitWidthCnt cleared to 0.
//   - STRT: vote 1 -> glitch, back to IDLE with no outputs; vote 0 -> DATA at the wrap.
//   - DATA: 8 bits, first received first; after bit 8 -> PARI if p_ParityEnable_i, else STOP.
//   - PARI: one bit, then STOP.
//   - STOP: on vote, update byte_o and return to IDLE immediately (not at the wrap), ready for back-to-back frames.
//  p_ParityEnable_i is sampled on IDLE->STRT and held for the frame.
//  byte_o packing (left shift):
//   - [11] start bit
//   - [10:3] data; [10] = first data bit received
//   - [2] parity bit, or 0 if parity disabled
//   - [1] stop bit
//   - [0] = 0
//  byte_o updates only in the cycle Byte_Synch_o asserts and holds otherwise.
//  Stop vote = 1: Byte_Synch_o pulses 1 clk after the stop vote, concurrent with the byte_o update.
//  Stop vote = 0: p_FrameError_o pulses instead; byte_o is not updated; no Byte_Synch_o.
//  Parity is not checked here; the analyser owns parity checking.
//  BaudSig_i coincident with an Rx edge: the sample uses the synchronised value of that clk.
// CONFIGURATION
//  RX_BREAK_DETECT_EN defined:
//   - adds output p_Break_o (1-clk pulse) when start, all data, parity (if enabled) and stop votes are all 0;
//   - asserts with p_FrameError_o;
//   - FSM stays in IDLE until synchronised Rx has been 1 for 16 ticks, then re-arms.
//  RX_BREAK_DETECT_EN undefined: no p_Break_o port; break is reported only as a frame error,
//   and the FSM re-arms on the next falling edge.
// TESTING
//  1. Parity off, frame 0x5A LSB-first, stop=1 -> one Byte_Synch_o, byte_o=12'b0_01011010_0_1_0; 8 Bit_Synch_o + stop.
//  2. Parity on, 0xA5 with even parity bit 0 -> byte_o=12'b0_10100101_0_1_0; a second frame back-to-back (no idle) is also captured.
//  3. Rx low for 5 ticks only -> STRT vote 1, return to IDLE, no Byte_Synch_o, no p_FrameError_o.
//  4. Stop bit driven 0 -> p_FrameError_o single pulse, byte_o holds previous value, next valid frame captured.
//  5. Single-tick glitch on data tick MID -> votes 1,0,1 give bit=1; byte_o correct.
//  6. rst pulsed during DATA bit 4 -> all outputs at reset values; next full frame 0x3C captured correctly.
//     With RX_BREAK_DETECT_EN: Rx held low for 2 frame times -> one p_Break_o, no further frames until 16 high ticks.

Source files
------------

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_bit_sampler                                        |
// | Description : UART Rx front end: synchroniser, 16x oversampling, 3-tick  |
// |               majority vote and 12-bit frame word assembly.              |
// |               Optional break detection under RX_BREAK_DETECT_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_bit_sampler #(
  parameter int SYNC_STAGES = 3,
  parameter int SAMPLE_MID  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rx_i,
  input  logic        BaudSig_i,
  input  logic        p_ParityEnable_i,
  output logic [11:0] byte_o,
  output logic        Bit_Synch_o,
  output logic        Byte_Synch_o,
  output logic [4:0]  State_o,
  output logic [3:0]  BitWidthCnt_o,
`ifdef RX_BREAK_DETECT_EN
  output logic        p_Break_o,
`endif
  output logic        p_FrameError_o
);

  localparam logic [3:0] c_TICK_A    = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] c_TICK_B    = 4'(SAMPLE_MID);
  localparam logic [3:0] c_TICK_C    = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] c_TICK_LAST = 4'd15;
  localparam logic [2:0] c_LAST_DATA = 3'd7;

  typedef enum logic [4:0] {
    IDLE = 5'b0_0001,
    STRT = 5'b0_0010,
    DATA = 5'b0_0100,
    PARI = 5'b0_1000,
    STOP = 5'b1_0000
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_rx_d;
  logic [3:0]             r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [2:0]             r_bitidx;
  logic                   r_par_en;
  logic [8:0]             r_frame;
  logic                   r_par;
  logic [11:0]            r_byte;
  logic                   r_bit_synch;
  logic                   r_byte_synch;
  logic                   r_ferr;

  logic w_rx;
  logic w_armed;
  logic w_fall;
  logic w_start;
  logic w_tick_a;
  logic w_tick_b;
  logic w_tick_c;
  logic w_wrap;
  logic w_vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_fill <= '0;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Rx_i};
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_rx_d <= w_rx;
    end
  end

  // Edges are ignored until the synchroniser holds real line data, so a line
  // that is low at reset release is not mistaken for a start bit.
  assign w_rx     = r_sync[SYNC_STAGES-1];
  assign w_armed  = r_fill[SYNC_STAGES];
  assign w_fall   = w_armed & r_rx_d & ~w_rx;
  assign w_tick_a = BaudSig_i && (r_cnt == c_TICK_A);
  assign w_tick_b = BaudSig_i && (r_cnt == c_TICK_B);
  assign w_tick_c = BaudSig_i && (r_cnt == c_TICK_C);
  assign w_wrap   = BaudSig_i && (r_cnt == c_TICK_LAST);
  assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

`ifdef RX_BREAK_DETECT_EN
  logic       r_all_zero;
  logic       r_hold;
  logic [3:0] r_hold_cnt;
  logic       r_brk;
  assign w_start   = w_fall & ~r_hold;
  assign p_Break_o = r_brk;
`else
  assign w_start   = w_fall;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_bitidx     <= 3'd0;
      r_par_en     <= 1'b0;
      r_frame      <= 9'd0;
      r_par        <= 1'b0;
      r_byte       <= 12'h000;
      r_bit_synch  <= 1'b0;
      r_byte_synch <= 1'b0;
      r_ferr       <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      r_all_zero   <= 1'b0;
      r_hold       <= 1'b0;
      r_hold_cnt   <= 4'd0;
      r_brk        <= 1'b0;
`endif
    end else begin
      r_bit_synch  <= 1'b0;
      r_byte_synch <= 1'b0;
      r_ferr       <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      r_brk        <= 1'b0;
`endif
      if (r_state != IDLE) begin
        if (BaudSig_i) r_cnt <= r_cnt + 4'd1;
        if (w_tick_a)  r_s0  <= w_rx;
        if (w_tick_b)  r_s1  <= w_rx;
      end

      case (r_state)
        IDLE: begin
`ifdef RX_BREAK_DETECT_EN
          // After a break the line must stay high for a full bit time.
          if (r_hold && BaudSig_i) begin
            if (!w_rx) begin
              r_hold_cnt <= 4'd0;
            end else if (r_hold_cnt == c_TICK_LAST) begin
              r_hold     <= 1'b0;
              r_hold_cnt <= 4'd0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end
          end
`endif
          if (w_start) begin
            r_state  <= STRT;
            r_cnt    <= 4'd0;
            r_bitidx <= 3'd0;
            r_par    <= 1'b0;
            r_par_en <= p_ParityEnable_i;
          end
        end

        STRT: begin
          if (w_tick_c) begin
            if (w_vote) begin
              r_state <= IDLE;
              r_cnt   <= 4'd0;
            end else begin
              r_frame <= {r_frame[7:0], w_vote};
`ifdef RX_BREAK_DETECT_EN
              r_all_zero <= 1'b1;
`endif
            end
          end else if (w_wrap) begin
            r_state <= DATA;
          end
        end

        DATA: begin
          if (w_tick_c) begin
            r_frame     <= {r_frame[7:0], w_vote};
            r_bit_synch <= 1'b1;
`ifdef RX_BREAK_DETECT_EN
            if (w_vote) r_all_zero <= 1'b0;
`endif
          end else if (w_wrap) begin
            if (r_bitidx == c_LAST_DATA) begin
              r_state  <= r_par_en ? PARI : STOP;
              r_bitidx <= 3'd0;
            end else begin
              r_bitidx <= r_bitidx + 3'd1;
            end
          end
        end

        PARI: begin
          if (w_tick_c) begin
            r_par       <= w_vote;
            r_bit_synch <= 1'b1;
`ifdef RX_BREAK_DETECT_EN
            if (w_vote) r_all_zero <= 1'b0;
`endif
          end else if (w_wrap) begin
            r_state <= STOP;
          end
        end

        STOP: begin
          // Return to IDLE at the vote, not the wrap, to catch back-to-back frames.
          if (w_tick_c) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_bit_synch <= 1'b1;
            if (w_vote) begin
              r_byte       <= {r_frame, r_par, 1'b1, 1'b0};
              r_byte_synch <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
`ifdef RX_BREAK_DETECT_EN
              if (r_all_zero) begin
                r_brk      <= 1'b1;
                r_hold     <= 1'b1;
                r_hold_cnt <= 4'd0;
              end
`endif
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign byte_o         = r_byte;
  assign Bit_Synch_o    = r_bit_synch;
  assign Byte_Synch_o   = r_byte_synch;
  assign State_o        = r_state;
  assign BitWidthCnt_o  = r_cnt;
  assign p_FrameError_o = r_ferr;

endmodule
`default_nettype wire
